// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I writeback constants and types.
// Used by the load queue and the writeback arbiter.
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]       xlen_t;

  typedef struct packed {
    reg_idx_t rd;
    xlen_t    data;
    logic     live;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LQ
  } wb_src_e;

  // One-hot decode of a destination; x0 never shows as busy.
  function automatic logic [NREGS-1:0] rd_onehot(
    input reg_idx_t rd
  );
    logic [NREGS-1:0] oh;
    oh     = '0;
    oh[rd] = (rd != '0);
    return oh;
  endfunction

endpackage

// File: rtl/wb_load_queue.sv
// wb_load_queue: circular FIFO of returning loads.
// Supports rd-match kill and a live-entry busy bitmap.
module wb_load_queue
  import rv32_pkg::*;
#(
  parameter int LQ_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  reg_idx_t         push_rd,
  input  xlen_t            push_data,
  input  logic             pop,
  input  logic             kill,
  input  reg_idx_t         kill_rd,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [NREGS-1:0] busy
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C =
    CNT_W'(LQ_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE =
    PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  wb_entry_t        mem_q [LQ_DEPTH];
  wb_entry_t        mem_d [LQ_DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] head_d;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W-1:0] tail_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign head    = mem_q[head_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next storage: kill matches, retire head, append
  // tail; a same-cycle push is older than the kill.
  always_comb begin
    for (int i = 0; i < LQ_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (kill && (mem_q[i].rd == kill_rd)) begin
        mem_d[i].live = 1'b0;
      end
    end
    if (pop_ok) begin
      mem_d[head_q].live = 1'b0;
    end
    if (push_ok) begin
      mem_d[tail_q].rd   = push_rd;
      mem_d[tail_q].data = push_data;
      mem_d[tail_q].live =
        !(kill && (push_rd == kill_rd));
    end
  end

  // Pointer and occupancy update.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_ok) begin
      head_d = head_q + PTR_ONE;
    end
    if (push_ok) begin
      tail_d = tail_q + PTR_ONE;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Busy bitmap: OR of live entries' destinations.
  always_comb begin
    busy = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (mem_q[i].live) begin
        busy = busy | rd_onehot(mem_q[i].rd);
      end
    end
  end

  // Queue state; reset drops every queued load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  a_count_bound: assert property (
    @(posedge clock) disable iff (!reset_n)
    count_q <= DEPTH_C
  );

  a_ptr_gap: assert property (
    @(posedge clock) disable iff (!reset_n)
    (count_q == '0 || count_q == DEPTH_C)
      |-> (head_q == tail_q)
  );

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU results and queued loads
// into the register file's single registered write port.
module regfile_writeback
  import rv32_pkg::*;
#(
  parameter int LQ_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  load_valid,
  input  logic [REG_ADDR_W-1:0] load_rd,
  input  logic [XLEN-1:0]       load_data,
  output logic                  load_ready,
  output logic                  rf_write,
  output logic [REG_ADDR_W-1:0] rf_write_reg,
  output logic [XLEN-1:0]       rf_write_data,
  output logic [NREGS-1:0]      busy
);

  wb_entry_t lq_head;
  logic      lq_full;
  logic      lq_empty;
  logic      lq_push;
  logic      lq_pop;
  logic      alu_win;
  logic      sel_alu;
  logic      sel_lq;
  wb_src_e   src;

  logic     rf_write_q;
  logic     rf_write_d;
  reg_idx_t rf_write_reg_q;
  reg_idx_t rf_write_reg_d;
  xlen_t    rf_write_data_q;
  xlen_t    rf_write_data_d;

  wb_load_queue #(
    .LQ_DEPTH (LQ_DEPTH)
  ) u_lq (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (lq_push),
    .push_rd   (load_rd),
    .push_data (load_data),
    .pop       (lq_pop),
    .kill      (alu_win),
    .kill_rd   (alu_rd),
    .head      (lq_head),
    .full      (lq_full),
    .empty     (lq_empty),
    .busy      (busy)
  );

  // Arbitration from registered queue state only;
  // a full queue forces the head out ahead of the ALU.
  always_comb begin
    alu_ready  = !lq_full;
    load_ready = !lq_full;
    alu_win    = alu_valid
              && (alu_rd != '0)
              && !lq_full;
    lq_push    = load_valid
              && (load_rd != '0)
              && !lq_full;
    sel_alu    = alu_win;
    sel_lq     = !alu_win && !lq_empty;
    src        = SRC_NONE;
    unique case (1'b1)
      sel_alu: src = SRC_ALU;
      sel_lq:  src = SRC_LQ;
      default: src = SRC_NONE;
    endcase
    lq_pop = (src == SRC_LQ);
  end

  // Write-port next value; killed heads burn the slot.
  always_comb begin
    rf_write_d      = 1'b0;
    rf_write_reg_d  = rf_write_reg_q;
    rf_write_data_d = rf_write_data_q;
    unique case (src)
      SRC_ALU: begin
        rf_write_d      = 1'b1;
        rf_write_reg_d  = alu_rd;
        rf_write_data_d = alu_data;
      end
      SRC_LQ: begin
        if (lq_head.live) begin
          rf_write_d      = 1'b1;
          rf_write_reg_d  = lq_head.rd;
          rf_write_data_d = lq_head.data;
        end
      end
      default: begin
        rf_write_d = 1'b0;
      end
    endcase
  end

  // Registered write port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_write_q      <= 1'b0;
      rf_write_reg_q  <= '0;
      rf_write_data_q <= '0;
    end else begin
      rf_write_q      <= rf_write_d;
      rf_write_reg_q  <= rf_write_reg_d;
      rf_write_data_q <= rf_write_data_d;
    end
  end

  assign rf_write      = rf_write_q;
  assign rf_write_reg  = rf_write_reg_q;
  assign rf_write_data = rf_write_data_q;

  a_no_x0_write: assert property (
    @(posedge clock) disable iff (!reset_n)
    rf_write |-> (rf_write_reg != '0)
  );

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed and random stimulus,
// checked against a queue-level writeback model.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        load_valid;
  logic [4:0]  load_rd;
  logic [31:0] load_data;
  logic        load_ready;
  logic        rf_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [31:0] busy;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  regfile_writeback #(
    .LQ_DEPTH (DEPTH)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .alu_ready     (alu_ready),
    .load_valid    (load_valid),
    .load_rd       (load_rd),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .rf_write      (rf_write),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          rd;
    logic [31:0] data;
    bit          live;
  } ment_t;

  ment_t       mq[$];
  bit          exp_w    = 1'b0;
  int          exp_reg  = 0;
  logic [31:0] exp_data = '0;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    foreach (mq[i]) begin
      if (mq[i].live) b[mq[i].rd] = 1'b1;
    end
    b[0] = 1'b0;
    return b;
  endfunction

  // Reference: a queue of pending loads; one write per edge.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      exp_w    = 1'b0;
      exp_reg  = 0;
      exp_data = '0;
    end else begin
      bit    full;
      bit    acc;
      ment_t e;
      full  = (mq.size() >= DEPTH);
      acc   = !full && alu_valid && (alu_rd != 0);
      exp_w = 1'b0;
      if (acc) begin
        exp_w    = 1'b1;
        exp_reg  = int'(alu_rd);
        exp_data = alu_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        if (e.live) begin
          exp_w    = 1'b1;
          exp_reg  = e.rd;
          exp_data = e.data;
        end
      end
      if (load_valid && !full && load_rd != 0) begin
        e.rd   = int'(load_rd);
        e.data = load_data;
        e.live = 1'b1;
        mq.push_back(e);
      end
      if (acc) begin
        foreach (mq[i]) begin
          if (mq[i].rd == int'(alu_rd)) mq[i].live = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("m_rf_write", {31'b0, rf_write},
            {31'b0, exp_w});
      if (exp_w) begin
        check("m_rf_reg", {27'b0, rf_write_reg},
              32'(exp_reg));
        check("m_rf_data", rf_write_data, exp_data);
      end
      check("m_alu_ready", {31'b0, alu_ready},
            {31'b0, mq.size() < DEPTH});
      check("m_load_ready", {31'b0, load_ready},
            {31'b0, mq.size() < DEPTH});
      check("m_busy", busy, model_busy());
    end
  end

  task automatic drive(
    input bit          av,
    input int          ard,
    input logic [31:0] ad,
    input bit          lv,
    input int          lrd,
    input logic [31:0] ld
  );
    alu_valid  = av;
    alu_rd     = 5'(ard);
    alu_data   = ad;
    load_valid = lv;
    load_rd    = 5'(lrd);
    load_data  = ld;
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    alu_valid  = 1'b0;
    alu_rd     = '0;
    alu_data   = '0;
    load_valid = 1'b0;
    load_rd    = '0;
    load_data  = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clock);

    check("rst_rf_write", {31'b0, rf_write}, 32'd0);
    check("rst_rf_reg", {27'b0, rf_write_reg}, 32'd0);
    check("rst_rf_data", rf_write_data, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_load_ready", {31'b0, load_ready}, 32'd1);
    check("rst_alu_ready", {31'b0, alu_ready}, 32'd1);

    chk_en = 1'b1;
    #2 reset_n = 1'b1;
    @(negedge clock);

    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    check("alu_wr", {31'b0, rf_write}, 32'd1);
    check("alu_reg", {27'b0, rf_write_reg}, 32'd5);
    check("alu_data", rf_write_data, 32'hDEADBEEF);
    drive(1, 0, 32'h1234, 0, 0, 0);
    check("alu_x0_wr", {31'b0, rf_write}, 32'd0);

    for (int k = 1; k <= 4; k++) begin
      drive(1, 10, 32'hA0A0_0000 + 32'(k),
            1, k, 32'(k) * 32'h1000);
    end
    check("drain_load_ready", {31'b0, load_ready}, 32'd0);
    check("drain_alu_ready", {31'b0, alu_ready}, 32'd0);
    check("drain_alu_reg", {27'b0, rf_write_reg}, 32'd10);
    check("drain_busy", busy, 32'h0000_001E);
    drive(1, 10, 32'hA0A0_0005, 0, 0, 0);
    check("drain_h1_reg", {27'b0, rf_write_reg}, 32'd1);
    check("drain_h1_data", rf_write_data, 32'h1000);
    check("drain_alu_ready2", {31'b0, alu_ready}, 32'd1);
    drive(1, 10, 32'hA0A0_0005, 0, 0, 0);
    check("drain_alu2_reg", {27'b0, rf_write_reg}, 32'd10);
    for (int k = 2; k <= 4; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      check("drain_reg", {27'b0, rf_write_reg}, 32'(k));
      check("drain_data", rf_write_data,
            32'(k) * 32'h1000);
    end

    drive(0, 0, 0, 1, 7, 32'h11);
    check("waw_push_wr", {31'b0, rf_write}, 32'd0);
    check("waw_busy_set", busy, 32'h0000_0080);
    drive(1, 7, 32'h22, 0, 0, 0);
    check("waw_alu_reg", {27'b0, rf_write_reg}, 32'd7);
    check("waw_alu_data", rf_write_data, 32'h22);
    check("waw_busy_clr", busy, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    check("waw_killed_pop", {31'b0, rf_write}, 32'd0);

    drive(1, 9, 32'h99, 1, 9, 32'h55);
    check("same_reg", {27'b0, rf_write_reg}, 32'd9);
    check("same_data", rf_write_data, 32'h99);
    check("same_busy", busy, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    check("same_killed1", {31'b0, rf_write}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    check("same_killed2", {31'b0, rf_write}, 32'd0);

    for (int k = 1; k <= 12; k++) begin
      drive(0, 0, 0, 1, k, 32'(k) * 32'h100);
      if (k == 1) begin
        check("wrap_first", {31'b0, rf_write}, 32'd0);
      end else begin
        check("wrap_reg", {27'b0, rf_write_reg},
              32'(k - 1));
        check("wrap_data", rf_write_data,
              32'(k - 1) * 32'h100);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    check("wrap_last_reg", {27'b0, rf_write_reg}, 32'd12);
    check("wrap_last_data", rf_write_data, 32'hC00);

    drive(1, 10, 32'hB0, 1, 3, 32'h333);
    drive(1, 11, 32'hB1, 1, 4, 32'h444);
    check("mrst_busy_pre", busy, 32'h0000_0018);
    #2 reset_n = 1'b0;
    #1;
    check("mrst_rf_write", {31'b0, rf_write}, 32'd0);
    check("mrst_busy", busy, 32'd0);
    check("mrst_load_ready", {31'b0, load_ready}, 32'd1);
    idle_inputs();
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      check("mrst_no_wr", {31'b0, rf_write}, 32'd0);
    end

    for (int c = 0; c < 3000; c++) begin
      int pa;
      int pl;
      pa = ((c / 400) % 2 == 0) ? 85 : 35;
      pl = ((c / 250) % 2 == 0) ? 70 : 30;
      if (!(alu_valid && mq.size() >= DEPTH)) begin
        alu_valid = ($urandom_range(0, 99) < pa);
        alu_rd    = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      load_valid = ($urandom_range(0, 99) < pl);
      load_rd    = 5'($urandom_range(0, 7));
      load_data  = $urandom;
      if (c == 1500) begin
        #2 reset_n = 1'b0;
        @(negedge clock);
        #2 reset_n = 1'b1;
      end
      @(negedge clock);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
